// File: rtl/rv_pkg.sv
// Shared RV32I issue-stage types: opcodes, ALU control codes, the issue record and FSM states.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Arithmetic and compare codes share encodings, so they live in two enums.
    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101,
        SLL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        BEQ = 3'b000,
        BNE = 3'b001,
        BLT = 3'b100,
        BGE = 3'b101
    } br_ctrl_e;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [2:0]      ctrl;
        logic            branch;
        logic [4:0]      rd;
        logic            regwrite;
        logic            illegal;
    } issue_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decode of one instruction plus its register operands into an issue record.
module rv_decode
    import rv_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output issue_t          dec
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] op2;
    logic [2:0]      ctrl;
    logic            branch;
    logic            regwrite;
    logic            legal;
    logic            unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    // Register indices arrive already resolved as rs1_data/rs2_data.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        op2      = rs2_data;
        ctrl     = ADD;
        branch   = 1'b0;
        regwrite = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                regwrite = 1'b1;
                legal    = (funct7 == 7'b0000000);
                case (funct3)
                    3'b000: begin
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        ctrl  = funct7[5] ? SUB : ADD;
                    end
                    3'b111:  ctrl = AND;
                    3'b110:  ctrl = OR;
                    3'b010:  ctrl = SLT;
                    3'b001:  ctrl = SLL;
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                regwrite = 1'b1;
                legal    = 1'b1;
                op2      = imm_i;
                case (funct3)
                    3'b000: ctrl = ADD;
                    3'b111: ctrl = AND;
                    3'b110: ctrl = OR;
                    3'b010: ctrl = SLT;
                    3'b001: begin
                        ctrl  = SLL;
                        op2   = {{(XLEN-5){1'b0}}, instr[24:20]};
                        legal = (funct7 == 7'b0000000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                regwrite = 1'b1;
                op2      = imm_i;
                legal    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_STORE: begin
                op2   = imm_s;
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                branch = 1'b1;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  ctrl = BEQ;
                    3'b001:  ctrl = BNE;
                    3'b100:  ctrl = BLT;
                    3'b101:  ctrl = BGE;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Unsupported encodings still flow downstream, but as inert no-ops.
        if (!legal) begin
            op2      = rs2_data;
            ctrl     = ADD;
            branch   = 1'b0;
            regwrite = 1'b0;
        end

        dec          = '0;
        dec.op1      = rs1_data;
        dec.op2      = op2;
        dec.ctrl     = ctrl;
        dec.branch   = branch;
        dec.rd       = regwrite ? instr[11:7] : 5'd0;
        dec.regwrite = regwrite;
        dec.illegal  = !legal;
    end

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage: decodes into a 2-entry skid buffer (head + skid) feeding the execute ALU.
module id_ex_issue
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  rs1_data,
    input  logic [DATA_WIDTH-1:0]  rs2_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  ALUop1,
    output logic [DATA_WIDTH-1:0]  ALUop2,
    output logic [2:0]             ALUctrl,
    output logic                   ALUBranch,
    output logic [4:0]             rd,
    output logic                   RegWrite,
    output logic                   illegal
);

    state_e state_q, state_d;
    issue_t head_q, head_d;
    issue_t skid_q, skid_d;
    issue_t dec;
    logic   accept;

    rv_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    // Both handshake outputs depend only on the state register.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && out_ready) begin
                        head_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StFull;
                    end else if (out_ready) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        head_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign ALUop1    = head_q.op1;
    assign ALUop2    = head_q.op2;
    assign ALUctrl   = head_q.ctrl;
    assign ALUBranch = head_q.branch;
    assign rd        = head_q.rd;
    assign RegWrite  = head_q.regwrite;
    assign illegal   = head_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: directed instructions with hand-computed decodes and a FIFO scoreboard.
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic [2:0]  ALUctrl;
    logic        ALUBranch;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        illegal;

    id_ex_issue #(
        .DATA_WIDTH  (32),
        .INSTR_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUop1    (ALUop1),
        .ALUop2    (ALUop2),
        .ALUctrl   (ALUctrl),
        .ALUBranch (ALUBranch),
        .rd        (rd),
        .RegWrite  (RegWrite),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  ctrl;
        logic        br;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t cur;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the stage behaves as a 2-deep FIFO of decoded records.
    always @(negedge clk) begin
        bit acc;
        if (!rst_n) begin
            q.delete();
            chk("rst out_valid", 32'(out_valid), 32'd0);
            chk("rst in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("ALUop1", ALUop1, q[0].op1);
                chk("ALUop2", ALUop2, q[0].op2);
                chk("ALUctrl", 32'(ALUctrl), 32'(q[0].ctrl));
                chk("ALUBranch", 32'(ALUBranch), 32'(q[0].br));
                chk("rd", 32'(rd), 32'(q[0].rd));
                chk("RegWrite", 32'(RegWrite), 32'(q[0].rw));
                chk("illegal", 32'(illegal), 32'(q[0].ill));
            end
            acc = in_valid && (q.size() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
        end
    end

    task automatic set_vec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_op2, input logic [2:0] e_ctrl, input logic e_br,
                           input logic [4:0] e_rd, input logic e_rw, input logic e_ill);
        instr    = i;
        rs1_data = a;
        rs2_data = b;
        cur.op1  = a;
        cur.op2  = e_op2;
        cur.ctrl = e_ctrl;
        cur.br   = e_br;
        cur.rd   = e_rd;
        cur.rw   = e_rw;
        cur.ill  = e_ill;
    endtask

    // Holds in_valid until the stage takes the entry; returns #1 after the accepting edge.
    task automatic wait_accept(input string name);
        bit done = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk({"accept ", name}, 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(2);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset ALUop1", ALUop1, 32'd0);
        chk("reset ALUctrl", 32'(ALUctrl), 32'd0);
        chk("reset ALUBranch", 32'(ALUBranch), 32'd0);
        chk("reset RegWrite", 32'(RegWrite), 32'd0);
        chk("reset rd", 32'(rd), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // add x3,x1,x2
        set_vec(32'h002081B3, 32'd5, 32'd7, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        wait_accept("add");
        chk("add out_valid", 32'(out_valid), 32'd1);
        chk("add op1", ALUop1, 32'd5);
        chk("add op2", ALUop2, 32'd7);
        chk("add rd", 32'(rd), 32'd3);
        chk("add RegWrite", 32'(RegWrite), 32'd1);
        // addi x1,x0,-4
        set_vec(32'hFFC00093, 32'd0, 32'h55, 32'hFFFFFFFC, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0);
        wait_accept("addi");
        chk("addi op2", ALUop2, 32'hFFFFFFFC);
        // slli x1,x1,3
        set_vec(32'h00309093, 32'hFFFFFFFC, 32'h66, 32'd3, 3'b111, 1'b0, 5'd1, 1'b1, 1'b0);
        wait_accept("slli");
        chk("slli op2", ALUop2, 32'd3);
        chk("slli ctrl", 32'(ALUctrl), 32'd7);
        // bge x1,x2
        set_vec(32'h0020D063, 32'd9, 32'd4, 32'd4, 3'b101, 1'b1, 5'd0, 1'b0, 1'b0);
        wait_accept("bge");
        chk("bge branch", 32'(ALUBranch), 32'd1);
        chk("bge ctrl", 32'(ALUctrl), 32'd5);
        chk("bge RegWrite", 32'(RegWrite), 32'd0);
        chk("bge rd", 32'(rd), 32'd0);
        // sub x5,x6,x7 ; lw x4,-8(x2) ; sw x5,12(x2)
        set_vec(32'h407302B3, 32'd10, 32'd3, 32'd3, 3'b001, 1'b0, 5'd5, 1'b1, 1'b0);
        wait_accept("sub");
        set_vec(32'hFF812203, 32'h100, 32'h33, 32'hFFFFFFF8, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0);
        wait_accept("lw");
        set_vec(32'h00512623, 32'h100, 32'h44, 32'd12, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        wait_accept("sw");
        chk("sw rd", 32'(rd), 32'd0);
        idle(2);

        // Backpressure: two fill head and skid, the third waits for in_ready.
        out_ready = 1'b0;
        set_vec(32'h00A4F433, 32'hF0F0, 32'h0FF0, 32'h0FF0, 3'b010, 1'b0, 5'd8, 1'b1, 1'b0);
        wait_accept("and");
        set_vec(32'hFF812203, 32'h200, 32'h0, 32'hFFFFFFF8, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0);
        wait_accept("lw2");
        set_vec(32'hFE512E23, 32'h300, 32'h5, 32'hFFFFFFFC, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        idle(3);
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full head stable", 32'(ALUctrl), 32'd2);
        out_ready = 1'b1;
        wait_accept("sw_neg");
        idle(3);

        // Flush from FULL with a pending input, then from ONE with a same-cycle accept.
        out_ready = 1'b0;
        set_vec(32'h407302B3, 32'd10, 32'd3, 32'd3, 3'b001, 1'b0, 5'd5, 1'b1, 1'b0);
        wait_accept("sub2");
        set_vec(32'h0020C063, 32'd1, 32'd2, 32'd2, 3'b100, 1'b1, 5'd0, 1'b0, 1'b0);
        wait_accept("blt");
        in_valid = 1'b1;
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush full out_valid", 32'(out_valid), 32'd0);
        chk("flush full in_ready", 32'(in_ready), 32'd1);
        set_vec(32'h002081B3, 32'd1, 32'd1, 32'd1, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        wait_accept("add_one");
        in_valid = 1'b1;
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush one out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        idle(3);

        // Illegal encodings still flow through as no-ops.
        set_vec(32'h0000007F, 32'h11, 32'h22, 32'h22, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        wait_accept("illegal_op");
        chk("illegal flag", 32'(illegal), 32'd1);
        chk("illegal RegWrite", 32'(RegWrite), 32'd0);
        set_vec(32'h022081B3, 32'd1, 32'd2, 32'd2, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        wait_accept("mul");
        idle(2);

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        set_vec(32'h002081B3, 32'd5, 32'd7, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        wait_accept("add_r1");
        set_vec(32'h0020D063, 32'd9, 32'd4, 32'd4, 3'b101, 1'b1, 5'd0, 1'b0, 1'b0);
        wait_accept("bge_r2");
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        set_vec(32'h002081B3, 32'd8, 32'd9, 32'd9, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        wait_accept("add_post");
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
